// File: rtl/add_sub_pkg.sv
// Shared constants and helpers for the pipelined adder/subtractor.
// Holds the add/subtract mode encodings and the saturation clamp constant
// used when the ADDSUB_SAT_EN build option is defined.
package add_sub_pkg;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

   // Clamp constant for a width-bit two's-complement value.
   // neg=0 gives the signed maximum, neg=1 gives the signed minimum.
   function automatic logic [63:0] sat_value(input int width, input logic neg);
      logic [63:0] msb;
      msb = 64'd1 << (width - 1);
      return neg ? msb : (msb - 64'd1);
   endfunction

endpackage

// File: rtl/add_sub_slice.sv
// Combinational SLICE_W-bit ripple-carry adder used as one pipeline slice.
// Also exports the carry into its MSB so the final slice can form the
// signed overflow term (carry into MSB xor carry out of MSB).
module add_sub_slice
   import add_sub_pkg::*;
#(
   parameter int SLICE_W = 4
) (
   input  logic [SLICE_W-1:0] a,
   input  logic [SLICE_W-1:0] b,
   input  logic               c_in,
   output logic [SLICE_W-1:0] sum,
   output logic               c_out,
   output logic               c_msb
);

   logic carry;

   // Bit-serial ripple through the slice, capturing the MSB carry-in.
   always_comb begin
      carry = c_in;
      sum   = '0;
      c_msb = 1'b0;
      for (int i = 0; i < SLICE_W; i++) begin
         if (i == SLICE_W - 1) begin
            c_msb = carry;
         end
         sum[i] = a[i] ^ b[i] ^ carry;
         carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
      end
      c_out = carry;
   end

endmodule

// File: rtl/pipelined_add_sub.sv
// Pipelined WIDTH-bit adder/subtractor built from STAGES ripple slices.
// Slice k adds bits [k*S +: S]; the operand bits not yet consumed and the
// partial sum travel down the stage registers with their valid bit.
// A single global advance signal stalls every stage at once.
// Build option: define ADDSUB_SAT_EN to saturate the result on signed
// overflow in the final stage (cout/overflow stay unsaturated).
module pipelined_add_sub
   import add_sub_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             overflow
);

   localparam int S = WIDTH / STAGES;

   if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
      $error("pipelined_add_sub: WIDTH must be >= 2 and a multiple of STAGES");
   end

   // Insert one S-bit slice sum into its position of the running sum.
   function automatic logic [WIDTH-1:0] merge_slice(input logic [WIDTH-1:0] base,
                                                    input logic [S-1:0]     part,
                                                    input int               k);
      logic [WIDTH-1:0] r;
      r            = base;
      r[k*S +: S]  = part;
      return r;
   endfunction

`ifdef ADDSUB_SAT_EN
   // Clamp value for an overflowed result; neg selects the signed minimum.
   function automatic logic [WIDTH-1:0] sat_result(input logic neg);
      logic [63:0] v;
      v = sat_value(WIDTH, neg);
      return v[WIDTH-1:0];
   endfunction
`endif

   logic             advance;
   logic [WIDTH-1:0] bp_in;
   logic             c_eff;

   // Stage registers (element STAGES-1 lives in the output registers).
   logic             vld_p [STAGES];
   logic [WIDTH-1:0] a_p   [STAGES];
   logic [WIDTH-1:0] bp_p  [STAGES];
   logic [WIDTH-1:0] sum_p [STAGES];
   logic             c_p   [STAGES];

   // Next-state values feeding each stage register.
   logic             vld_n [STAGES];
   logic [WIDTH-1:0] a_n   [STAGES];
   logic [WIDTH-1:0] bp_n  [STAGES];
   logic [WIDTH-1:0] sum_n [STAGES];
   logic             c_n   [STAGES];

   logic [S-1:0]     sl_a  [STAGES];
   logic [S-1:0]     sl_b  [STAGES];
   logic [S-1:0]     sl_s  [STAGES];
   logic             sl_ci [STAGES];
   logic             sl_co [STAGES];
   logic             sl_cm [STAGES];

   logic [WIDTH-1:0] res_last;
   logic             ovf_last;
   logic [WIDTH-1:0] result_q;
   logic             cout_q;
   logic             ovf_q;

   assign advance  = !vld_p[STAGES-1] || out_ready;
   assign in_ready = advance;

   assign bp_in = (sub == MODE_SUB) ? ~b   : b;
   assign c_eff = (sub == MODE_SUB) ? ~cin : cin;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      if (k == 0) begin : g_first
         assign vld_n[k] = in_valid;
         assign a_n[k]   = a;
         assign bp_n[k]  = bp_in;
         assign sl_ci[k] = c_eff;
         assign sum_n[k] = merge_slice('0, sl_s[k], k);
      end else begin : g_next
         assign vld_n[k] = vld_p[k-1];
         assign a_n[k]   = a_p[k-1];
         assign bp_n[k]  = bp_p[k-1];
         assign sl_ci[k] = c_p[k-1];
         assign sum_n[k] = merge_slice(sum_p[k-1], sl_s[k], k);
      end

      assign sl_a[k] = a_n[k][k*S +: S];
      assign sl_b[k] = bp_n[k][k*S +: S];
      assign c_n[k]  = sl_co[k];

      add_sub_slice #(.SLICE_W(S)) u_slice (
         .a     (sl_a[k]),
         .b     (sl_b[k]),
         .c_in  (sl_ci[k]),
         .sum   (sl_s[k]),
         .c_out (sl_co[k]),
         .c_msb (sl_cm[k])
      );
   end

   assign ovf_last = sl_co[STAGES-1] ^ sl_cm[STAGES-1];

`ifdef ADDSUB_SAT_EN
   assign res_last = ovf_last ? sat_result(a_n[STAGES-1][WIDTH-1]) : sum_n[STAGES-1];
`else
   assign res_last = sum_n[STAGES-1];
`endif

   // Stage valids: cleared by reset, shifted together on advance.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < STAGES; k++) vld_p[k] <= 1'b0;
      end else if (advance) begin
         for (int k = 0; k < STAGES; k++) vld_p[k] <= vld_n[k];
      end
   end

   // Intermediate stage data: no reset, moves only on advance.
   always_ff @(posedge clk) begin
      if (advance) begin
         for (int k = 0; k < STAGES - 1; k++) begin
            a_p[k]   <= a_n[k];
            bp_p[k]  <= bp_n[k];
            sum_p[k] <= sum_n[k];
            c_p[k]   <= c_n[k];
         end
      end
   end

   // Final stage output registers, held stable while stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         result_q <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else if (advance) begin
         result_q <= res_last;
         cout_q   <= c_n[STAGES-1];
         ovf_q    <= ovf_last;
      end
   end

   assign out_valid = vld_p[STAGES-1];
   assign result    = result_q;
   assign cout      = cout_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Directed bench for pipelined_add_sub (WIDTH=8, STAGES=2), followed by a
// short randomized run scored against an arithmetic reference model.
module tb_pipelined_add_sub;

   localparam int W  = 8;
   localparam int ST = 2;

`ifdef ADDSUB_SAT_EN
   localparam logic [W-1:0] R_7F_01 = 8'h7F;
   localparam logic [W-1:0] R_80_01 = 8'h80;
   localparam logic [W-1:0] R_80_80 = 8'h80;
`else
   localparam logic [W-1:0] R_7F_01 = 8'h80;
   localparam logic [W-1:0] R_80_01 = 8'h7F;
   localparam logic [W-1:0] R_80_80 = 8'h00;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         cout;
   logic         overflow;

   int n_tests = 0;
   int n_fail  = 0;

   typedef logic [W+1:0] exp_t;
   exp_t q[$];

   always #5 clk = ~clk;

   pipelined_add_sub #(.WIDTH(W), .STAGES(ST)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .cout      (cout),
      .overflow  (overflow)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: {overflow, cout, result} straight from the arithmetic definition.
   function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                  input logic mc, input logic ms);
      logic [W-1:0] bp;
      logic         c;
      logic [W:0]   s;
      logic [W-1:0] r;
      logic         o;
      bp = ms ? ~mb : mb;
      c  = ms ? ~mc : mc;
      s  = {1'b0, ma} + {1'b0, bp} + {{W{1'b0}}, c};
      r  = s[W-1:0];
      o  = (ma[W-1] == bp[W-1]) && (r[W-1] != ma[W-1]);
`ifdef ADDSUB_SAT_EN
      if (o) r = ma[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
      return {o, s[W], r};
   endfunction

   // One isolated transaction with out_ready=1, checked at the expected latency.
   task automatic run_one(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic tc, input logic ts,
                          input logic [W-1:0] er, input logic ec, input logic eo);
      a = ta; b = tb_; cin = tc; sub = ts;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      repeat (ST - 1) step();
      check({tag, "_vld"}, out_valid, 1);
      check({tag, "_res"}, result, er);
      check({tag, "_cout"}, cout, ec);
      check({tag, "_ovf"}, overflow, eo);
      step();
   endtask

   initial begin
      exp_t e;

      // Reset held with in_valid asserted
      rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      a = 8'h55; b = 8'h22; cin = 1'b1; sub = 1'b0;
      repeat (3) step();
      check("rst_vld", out_valid, 0);
      check("rst_res", result, 0);
      check("rst_cout", cout, 0);
      check("rst_ovf", overflow, 0);
      check("rst_rdy", in_ready, 1);
      rst = 1'b0; in_valid = 1'b0;
      step();
      check("idle_vld", out_valid, 0);

      // Directed arithmetic cases
      run_one("add7F01", 8'h7F, 8'h01, 1'b0, 1'b0, R_7F_01, 1'b0, 1'b1);
      run_one("sub0001", 8'h00, 8'h01, 1'b0, 1'b1, 8'hFF,   1'b0, 1'b0);
      run_one("sub8001", 8'h80, 8'h01, 1'b0, 1'b1, R_80_01, 1'b1, 1'b1);
      run_one("addFF00c", 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00,  1'b1, 1'b0);
      run_one("addFF01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00,   1'b1, 1'b0);
      run_one("sub0503b", 8'h05, 8'h03, 1'b1, 1'b1, 8'h01,  1'b1, 1'b0);
      run_one("add8080", 8'h80, 8'h80, 1'b0, 1'b0, R_80_80, 1'b1, 1'b1);
      run_one("add0F01", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10,   1'b0, 1'b0);

      // Backpressure with four back-to-back inputs
      cin = 1'b0; sub = 1'b0;
      out_ready = 1'b1; in_valid = 1'b1; a = 8'h01; b = 8'h01;
      step();
      a = 8'h02; b = 8'h02; out_ready = 1'b0;
      step();
      check("bp_full_rdy", in_ready, 0);
      check("bp_full_vld", out_valid, 1);
      check("bp_full_res", result, 8'h02);
      a = 8'h03; b = 8'h03;
      repeat (2) step();
      check("bp_hold_rdy", in_ready, 0);
      check("bp_hold_vld", out_valid, 1);
      check("bp_hold_res", result, 8'h02);
      out_ready = 1'b1;
      step();
      check("bp_r2_res", result, 8'h04);
      a = 8'h04; b = 8'h04;
      step();
      check("bp_r3_res", result, 8'h06);
      in_valid = 1'b0;
      step();
      check("bp_r4_res", result, 8'h08);
      check("bp_r4_vld", out_valid, 1);
      step();
      check("bp_empty_vld", out_valid, 0);

      // Reset asserted while stalled with two transactions in flight
      out_ready = 1'b1; in_valid = 1'b1; a = 8'h10; b = 8'h01;
      step();
      a = 8'h20;
      step();
      in_valid = 1'b0; out_ready = 1'b0;
      check("mid_pre_vld", out_valid, 1);
      rst = 1'b1;
      step();
      check("mid_rst_vld", out_valid, 0);
      check("mid_rst_rdy", in_ready, 1);
      rst = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("mid_post_vld", out_valid, 0);
      end

      // Randomized traffic with random backpressure, then drain
      for (int cyc = 0; cyc < 400; cyc++) begin
         if (cyc < 360) begin
            in_valid  = 1'($urandom_range(0, 1));
            a         = W'($urandom);
            b         = W'($urandom);
            cin       = 1'($urandom_range(0, 1));
            sub       = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
         end else begin
            in_valid  = 1'b0;
            out_ready = 1'b1;
         end
         #1;
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               check("rnd_spurious", 1, 0);
            end else begin
               e = q.pop_front();
               check("rnd_res", result, e[W-1:0]);
               check("rnd_cout", cout, e[W]);
               check("rnd_ovf", overflow, e[W+1]);
            end
         end
         if (in_valid && in_ready) q.push_back(model(a, b, cin, sub));
         step();
      end
      check("rnd_drain", q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
